// File: rtl/debouncer_pkg.sv
// Shared definitions for the button debouncer bank: channel state encoding,
// 50 MHz default timing and a width helper.
package debouncer_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PRESS   = 3'd1,
      PULSE   = 3'd2,
      HELD    = 3'd3,
      RELEASE = 3'd4,
      LOCK    = 3'd5
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES     = 50000;
   localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
   localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce/typematic FSM with a
// debounce counter and an auto-repeat counter, registered pulse and level.
module debounce_channel
   import debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic block,
   input  logic repeat_en,
   input  logic btn_in,
   output logic pulse_next,
   output logic btn_pulse,
   output logic btn_level
);

   // Repeat intervals below 2 would allow back-to-back pulses.
   localparam int DELAY_EFF = (REPEAT_DELAY_CYCLES < 2) ? 2 : REPEAT_DELAY_CYCLES;
   localparam int RATE_EFF  = (REPEAT_RATE_CYCLES < 2) ? 2 : REPEAT_RATE_CYCLES;
   localparam int MAX_A     = (DEBOUNCE_CYCLES > DELAY_EFF) ? DEBOUNCE_CYCLES : DELAY_EFF;
   localparam int MAX_ALL   = (MAX_A > RATE_EFF) ? MAX_A : RATE_EFF;
   localparam int CNT_W     = clog2(MAX_ALL) + 1;

   localparam logic [CNT_W-1:0] DEB_T      = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST_T = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_T    = CNT_W'(DELAY_EFF);
   localparam logic [CNT_W-1:0] RATE_T     = CNT_W'(RATE_EFF);
   localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic             sync_meta;
   logic             sync_s;
   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] rep_cnt;
   logic [CNT_W-1:0] rep_cnt_next;
   logic [CNT_W-1:0] rep_target;
   logic             rep_phase;
   logic             rep_phase_next;
   logic             level_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync_s    <= 1'b0;
      end else begin
         sync_meta <= btn_in;
         sync_s    <= sync_meta;
      end
   end

   // rep_phase: 0 while waiting out the initial delay, 1 once repeating at the rate.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      rep_cnt_next   = rep_cnt;
      rep_phase_next = rep_phase;
      pulse_next     = 1'b0;
      level_next     = 1'b0;
      rep_target     = rep_phase ? RATE_T : DELAY_T;
      case (state)
         IDLE: begin
            if (sync_s && !block) begin
               state_next = PRESS;
               cnt_next   = ONE;
            end
         end
         PRESS: begin
            if (!sync_s || block) begin
               state_next = IDLE;
            end else if (cnt == DEB_T) begin
               state_next = PULSE;
            end else begin
               cnt_next = sat_inc(cnt);
            end
         end
         PULSE: begin
            pulse_next     = 1'b1;
            level_next     = 1'b1;
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
            state_next     = HELD;
         end
         HELD: begin
            level_next = 1'b1;
            if (block) begin
               state_next = LOCK;
               cnt_next   = '0;
            end else if (!sync_s) begin
               state_next = RELEASE;
               cnt_next   = ONE;
            end else if (repeat_en) begin
               if (sat_inc(rep_cnt) == rep_target) begin
                  pulse_next     = 1'b1;
                  rep_cnt_next   = '0;
                  rep_phase_next = 1'b1;
               end else begin
                  rep_cnt_next = sat_inc(rep_cnt);
               end
            end else begin
               rep_cnt_next   = '0;
               rep_phase_next = 1'b0;
            end
         end
         RELEASE: begin
            level_next = 1'b1;
            if (block) begin
               state_next = LOCK;
               cnt_next   = '0;
            end else if (sync_s) begin
               state_next = HELD;
            end else if (cnt == DEB_T) begin
               state_next = IDLE;
            end else begin
               cnt_next = sat_inc(cnt);
            end
         end
         LOCK: begin
            if (!sync_s && !block) begin
               if (cnt == DEB_LAST_T) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = sat_inc(cnt);
               end
            end else begin
               cnt_next = '0;
            end
         end
         default: begin
            state_next     = IDLE;
            cnt_next       = '0;
            rep_cnt_next   = '0;
            rep_phase_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rep_cnt   <= '0;
         rep_phase <= 1'b0;
         btn_pulse <= 1'b0;
         btn_level <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         rep_cnt   <= rep_cnt_next;
         rep_phase <= rep_phase_next;
         btn_pulse <= pulse_next;
         btn_level <= level_next;
      end
   end

endmodule

// File: rtl/button_debouncer_bank.sv
// Bank of independent debounced button channels with a shared block input
// and a registered any-pulse summary.
module button_debouncer_bank
   import debouncer_pkg::*;
#(
   parameter int NUM_BTNS            = 4,
   parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
   parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                block,
   input  logic [NUM_BTNS-1:0] repeat_en,
   input  logic [NUM_BTNS-1:0] btn_in,
   output logic [NUM_BTNS-1:0] btn_pulse,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic                any_pulse
);

   logic [NUM_BTNS-1:0] pulse_next;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
         .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .block     (block),
         .repeat_en (repeat_en[g]),
         .btn_in    (btn_in[g]),
         .pulse_next(pulse_next[g]),
         .btn_pulse (btn_pulse[g]),
         .btn_level (btn_level[g])
      );
   end

   // Built from the channels' next-pulse terms so it lands in the same cycle as btn_pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         any_pulse <= 1'b0;
      end else begin
         any_pulse <= |pulse_next;
      end
   end

endmodule

// File: doc/button_debouncer_bank.md
Name: button_debouncer_bank

Overview:
Multi-channel successor to the single-button debouncer used by the sudoku controller front end. It takes N raw pushbutton inputs, synchronises and debounces each one (press and release), and emits a one-cycle press pulse per channel. It adds optional per-channel typematic auto-repeat for held navigation keys, and a global block input with lockout semantics. It sits between the board pins and the game controller FSM.

Parameters:
NUM_BTNS, 4, number of independent button channels
DEBOUNCE_CYCLES, 50000, stable cycles required for press and for release (1 ms @ 50 MHz); must be >= 2
REPEAT_DELAY_CYCLES, 25000000, held cycles from the first pulse to the first auto-repeat pulse (500 ms)
REPEAT_RATE_CYCLES, 5000000, cycles between subsequent auto-repeat pulses (100 ms)
CNT_W, derived, clog2 of the largest cycle parameter plus 1; local, not overridable

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
block  input  1  global suppress; while high, no pulses are emitted and held buttons enter lockout
repeat_en  input  NUM_BTNS  per-channel auto-repeat enable, sampled every cycle
btn_in  input  NUM_BTNS  raw asynchronous buttons, 1 = pressed
btn_pulse  output  NUM_BTNS  registered one-cycle press/repeat pulse
btn_level  output  NUM_BTNS  registered debounced pressed level
any_pulse  output  1  registered OR of btn_pulse, same cycle as btn_pulse

Behaviour:
- Reset: all outputs are 0, all channels go to IDLE, and counters and synchronisers are 0. Reset is asynchronous, so outputs clear immediately, including mid-count or mid-pulse.
- Each channel uses a 2-flop synchroniser (s). All FSM decisions use s.
- IDLE: if s=1 and block=0, go to PRESS with cnt=1.
- PRESS: if s=0 or block=1, go to IDLE. If cnt==DEBOUNCE_CYCLES, go to PULSE. Otherwise cnt++.
- PULSE: assert btn_pulse for one cycle, set btn_level=1, clear rep_cnt, and go to HELD.
- Press latency: btn_in is sampled high at edge 0 and held. btn_pulse is high during the cycle after edge DEBOUNCE_CYCLES+3. btn_level rises on the same edge.
- HELD:
  - block=1 goes to LOCK.
  - s=0 goes to RELEASE with cnt=1.
  - If repeat_en=1, rep_cnt counts each cycle.
  - The first repeat pulse fires exactly REPEAT_DELAY_CYCLES edges after the initial pulse. Later repeat pulses follow every REPEAT_RATE_CYCLES edges.
  - If repeat_en=0, rep_cnt is held at 0 and no repeats fire.
  - Dropping repeat_en mid-hold aborts the sequence. Re-raising it restarts the delay phase.
- RELEASE:
  - block=1 goes to LOCK.
  - s=1 returns to HELD with no pulse; rep_cnt is frozen across the glitch.
  - If cnt==DEBOUNCE_CYCLES, go to IDLE and set btn_level=0. Otherwise cnt++.
- LOCK: btn_level=0 and no pulses. Leave only to IDLE, and only after s=0 for DEBOUNCE_CYCLES consecutive cycles with block=0. Lifting block while the button is still held never produces a pulse.
- btn_pulse is never high on two consecutive cycles. When REPEAT_RATE_CYCLES<2, the rate is clamped to 2.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses.
- A block assertion in the same cycle that the PULSE state is entered still emits that pulse; block takes effect from the next state decision.
- Counters saturate and never wrap. cnt is only compared for equality against targets below 2^CNT_W.
- Unreachable state encodings go to IDLE with outputs 0.

Decomposition:
- debouncer_pkg holds:
  - the 3-bit state encoding: IDLE, PRESS, PULSE, HELD, RELEASE, LOCK
  - default timing constants for 50 MHz
  - a clog2 helper function
- One sub-module, debounce_channel, contains the synchroniser, FSM and both counters for one button. The bank instantiates it NUM_BTNS times in a generate loop and builds the OR for any_pulse.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3 and NUM_BTNS=4.
- Clean press: btn_in[0]=1 from edge 0 for 30 cycles, repeat_en=0 -> single btn_pulse[0]=1 after edge 7, btn_level[0]=1 from edge 7. btn_level falls 7 edges after the release sample. any_pulse mirrors btn_pulse.
- Bounce: btn_in[1] toggles pattern 1,1,1,0 for 40 cycles -> btn_pulse and btn_level stay 0.
- Auto-repeat: repeat_en[2]=1, btn_in[2] held 40 cycles -> pulses after edges 7, 17, 20, 23, 26, ... and never on adjacent cycles. Stop after release debounce.
- Release glitch: during HELD, btn_in[0]=0 for 2 cycles then 1 -> no extra pulse, btn_level stays 1, repeat phase unchanged.
- Block lockout: press btn_in[3], raise block 3 cycles after the pulse, drop block while still held -> no further pulses and btn_level=0. Release for 4 or more cycles, then re-press -> a new pulse after 7 edges.
- Simultaneous plus reset: press all 4 channels at edge 0 -> 4 simultaneous pulses. Assert reset asynchronously during a second press count -> all outputs 0 immediately, and no pulse after reset release until a fresh debounced press.
